// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Iterative restoring divider. Produces one quotient bit per clock, MSB first.
//   Valid/ready handshake on both sides, a single division in flight.
//   A zero divisor skips the iteration and reports an all-ones quotient with div_zero set.
module seq_restoring_divider #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [DVD_W-1:0] dvd_r;
  logic [DVS_W-1:0] dvs_r;
  // The partial remainder always ends an iteration below the divisor, so its
  // top bit is structurally zero and only the low DVS_W bits are stored.
  logic [DVS_W-1:0] pr_r;
  logic [CNT_W-1:0] cnt_r;

  logic [DVS_W:0]   shifted_s;
  logic [DVS_W:0]   trial_s;
  logic             borrow_s;
  logic [DVS_W-1:0] pr_next_s;
  logic [DVD_W-1:0] dvd_next_s;

  // Core is ready only while idle and not being reset.
  assign in_ready = (state_r == IDLE) && !rst;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    shifted_s = {pr_r, dvd_r[DVD_W-1]};
    trial_s   = shifted_s - {1'b0, dvs_r};
    // shifted_s < 2*divisor, so the top bit of the difference is exactly the borrow.
    borrow_s  = trial_s[DVS_W];
    if (borrow_s) begin
      pr_next_s = shifted_s[DVS_W-1:0];
    end else begin
      pr_next_s = trial_s[DVS_W-1:0];
    end
    // Quotient bits enter at the bottom as the dividend bits leave at the top.
    dvd_next_s = {dvd_r[DVD_W-2:0], ~borrow_s};
  end

  // Control FSM plus datapath and result registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      out_valid <= 1'b0;
      quotient  <= {DVD_W{1'b0}};
      remainder <= {DVS_W{1'b0}};
      div_zero  <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      dvd_r     <= {DVD_W{1'b0}};
      dvs_r     <= {DVS_W{1'b0}};
      pr_r      <= {DVS_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            pr_r  <= {DVS_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            if (divisor == {DVS_W{1'b0}}) begin
              // Result is known at once; out_valid follows in the DONE cycle.
              quotient  <= {DVD_W{1'b1}};
              remainder <= {DVS_W{1'b0}};
              div_zero  <= 1'b1;
              state_r   <= DONE;
            end else begin
              div_zero <= 1'b0;
              state_r  <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          dvd_r <= dvd_next_s;
          pr_r  <= pr_next_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_W'(DVD_W - 1)) begin
            quotient  <= dvd_next_s;
            remainder <= pr_next_s;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider
//   Scoreboard bench: the driver pushes the arithmetic expectation for every
//   accepted division, a negedge monitor pops and compares each presented result.
module tb_seq_restoring_divider;

  localparam int DVD_W = 8;
  localparam int DVS_W = 4;
  localparam int QMAX  = (1 << DVD_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DVD_W-1:0] dividend = '0;
  logic [DVS_W-1:0] divisor = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             div_zero;

  seq_restoring_divider #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   stall_pct = 0;
  int   hold_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer division, zero divisor gives all ones / 0.
  task automatic send(input int a, input int b);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    dividend = a[DVD_W-1:0];
    divisor  = b[DVS_W-1:0];
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("accept_in_ready", in_ready, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    e.a   = a;
    e.b   = b;
    e.q   = (b == 0) ? QMAX : a / b;
    e.r   = (b == 0) ? 0 : a % b;
    e.dz  = (b == 0) ? 1 : 0;
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = DVD_W'($urandom);
    divisor  = DVS_W'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: pop on each new result, then hold outputs stable until transfer.
  exp_t cur;
  logic seen = 1'b0;
  logic drained = 1'b0;
  int   hold_cnt = 0;
  always @(negedge clk) begin
    if (drained) begin
      check("drain_out_valid", out_valid, 0);
      check("drain_in_ready", in_ready, 1);
      drained = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        check("result_queue_depth", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check("quotient", quotient, cur.q);
          check("remainder", remainder, cur.r);
          check("div_zero", div_zero, cur.dz);
          check("latency", cyc - cur.acc, (cur.dz != 0) ? 1 : DVD_W);
          if (cur.b != 0) begin
            check("invariant_sum", quotient * cur.b + remainder, cur.a);
            check("invariant_rem_lt_dvs", (remainder < cur.b) ? 1 : 0, 1);
          end
        end else begin
          cur.q  = quotient;
          cur.r  = remainder;
          cur.dz = div_zero;
        end
        seen     = 1'b1;
        hold_cnt = hold_req;
      end else begin
        check("stable_quotient", quotient, cur.q);
        check("stable_remainder", remainder, cur.r);
        check("stable_div_zero", div_zero, cur.dz);
      end
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
        check("busy_in_ready", in_ready, 0);
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      if (out_ready) begin
        seen    = 1'b0;
        drained = 1'b1;
      end
    end else begin
      out_ready = ($urandom_range(1) == 1);
    end
  end

  initial begin
    int n;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed cases, including the boundaries.
    send(200, 7);
    send(255, 1);
    send(5, 9);
    send(0, 15);
    send(225, 15);
    send(100, 0);
    wait_drain();

    // Backpressure: result held for 5 cycles, a busy-time request is ignored.
    hold_req = 5;
    send(200, 7);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_out_valid_seen", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 8'd9;
    divisor  = 4'd3;
    check("stall_pulse_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_drain();
    hold_req = 0;

    // Reset in the 4th CALC cycle, then a fresh division.
    send(200, 7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_div_zero", div_zero, 0);
    check("midrst_in_ready_in_rst", in_ready, 0);
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    send(45, 6);
    wait_drain();

    // Exhaustive sweep with random result stalls, then random operand pairs.
    stall_pct = 30;
    for (int a = 0; a <= QMAX; a++) begin
      for (int b = 0; b < (1 << DVS_W); b++) begin
        send(a, b);
      end
    end
    repeat (200) send(int'($urandom_range(QMAX)), int'($urandom_range((1 << DVS_W) - 1)));
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
